sprite_renderer: RTL and testbench
==================================

// Module: sprite_renderer
// PURPOSE
//  Per-pixel sprite fetch stage that drives the address port of the sprite ROM and consumes its data.
//  - Input side: the VGA scan position.
//  - Output side: 24-bit RGB plus an opaque flag, which feed the colour mapper / layer mux.
//  - Handles sprite hit test, animation frame stepping, ROM-latency alignment, palette lookup and transparency.
// PARAMETERS
//  SPR_W      60      sprite width in pixels
//  SPR_H      40      sprite height in pixels
//  N_FRAMES   1       animation frames stored back-to-back in ROM (stride SPR_W*SPR_H)
//  ANIM_DIV   8       number of frame_start pulses per animation step
//  TRANSP_IDX 0       palette index treated as transparent
// PORTS
//  Clk          in   1   system clock
//  Reset        in   1   asynchronous, active-high reset
//  frame_start  in   1   one-cycle pulse at start of vertical blank
//  pix_valid    in   1   DrawX/DrawY valid this cycle (active video)
//  DrawX        in   10  current pixel column
//  DrawY        in   10  current pixel row
//  sprite_x     in   10  sprite top-left column (shadow; latched at frame_start)
//  sprite_y     in   10  sprite top-left row (shadow; latched at frame_start)
//  sprite_vis   in   1   sprite enable (shadow; latched at frame_start)
//  anim_en      in   1   animation stepping enable
//  mirror       in   1   horizontal flip (shadow); present only with SPRITE_MIRROR_EN
//  rom_addr     out  19  sprite ROM read address (registered)
//  rom_data     in   5   sprite ROM palette index (ROM registers it, 1-cycle latency)
//  red          out  8   pixel red
//  green        out  8   pixel green
//  blue         out  8   pixel blue
//  pix_opaque   out  1   sprite pixel present and not transparent
//  out_valid    out  1   red/green/blue/pix_opaque correspond to a pix_valid input
// BEHAVIOUR
//  - Reset values:
//    - all outputs 0; latched x/y/vis/mirror 0; anim frame 0; ANIM_DIV counter 0.
//    - Sprite stays invisible until the first frame_start after reset, including reset mid-frame.
//  - Latching: on frame_start, register sprite_x/y/vis (and mirror).
//    - A pixel sampled in the same cycle as frame_start uses the previous latched values.
//  - Hit test, evaluated in 11-bit unsigned arithmetic so no wrap:
//    - hit = vis & pix_valid & DrawX>=x & DrawX<x+SPR_W & DrawY>=y & DrawY<y+SPR_H.
//    - x+SPR_W > 639 is legal: the sprite is clipped, never wrapped.
//  - Address: dx=DrawX-x, dy=DrawY-y, rom_addr = frame*SPR_W*SPR_H + dy*SPR_W + dx.
//    - On a miss, rom_addr holds its previous value.
//  - Pipeline, input sampled at edge N:
//    - N+1: rom_addr and hit/valid registered.
//    - N+2: rom_data valid.
//    - N+3: RGB, pix_opaque and out_valid registered.
//    - Fixed latency 3; one pixel per cycle; no stalls.
//  - Output: pix_opaque = hit & (rom_data != TRANSP_IDX); RGB = palette[rom_data] if pix_opaque, else 0.
//    - out_valid = pix_valid delayed 3 cycles, independent of hit.
//  - Animation, counted on frame_start:
//    - When anim_en=1, the divider increments; on reaching ANIM_DIV-1 it clears and frame advances.
//    - frame wraps N_FRAMES-1 -> 0. anim_en=0 freezes both the divider and frame.
//    - The frame change takes effect on the same edge as the position latch.
//  - Elaboration check: N_FRAMES*SPR_W*SPR_H must not exceed 2^19; otherwise $error.
// CONFIGURATION
//  - SPRITE_MIRROR_EN defined:
//    - mirror port exists and is latched at frame_start.
//    - When the latched mirror is 1, dx' = SPR_W-1-dx is used in the address.
//  - SPRITE_MIRROR_EN undefined:
//    - no mirror port; dx is used unmodified. Latency is identical in both builds.
// STRUCTURE
//  - Package sprite_pkg:
//    - rgb_t struct {r,g,b: 8 bits}
//    - pal_idx_t (5 bits)
//    - PALETTE constant (32 x rgb_t)
//    - SCREEN_W=640, SCREEN_H=480
//  - Sub-module sprite_palette: registered 32-entry index->rgb_t lookup, occupying pipeline stage N+3.
// TESTING
//  - Reset, then frame_start with x=100,y=50,vis=1; scan DrawX=100,DrawY=50:
//    - 3 cycles later out_valid=1, pix_opaque per ROM[0], rom_addr=0.
//  - Boundaries at x=100,y=50, SPR 60x40:
//    - DrawX=159,DrawY=89 -> rom_addr=2399, hit.
//    - DrawX=160 -> pix_opaque=0, RGB=0.
//    - DrawX=99 -> miss.
//  - Clipping: x=620, DrawX=639,DrawY=y -> rom_addr=19; no hit at DrawX=0..19 of that row.
//  - Shadow: change sprite_x from 100 to 300 mid-frame:
//    - DrawX=100 still hits until the next frame_start.
//    - After it, DrawX=300 hits and DrawX=100 misses.
//  - Animation: N_FRAMES=2, ANIM_DIV=2, anim_en=1; four frame_starts:
//    - frame sequence 0,1,1,0 observed via rom_addr base 0/2400.
//    - anim_en=0 freezes the sequence.
//  - Mirror (SPRITE_MIRROR_EN): mirror=1, DrawX=x -> rom_addr=59.
//    - Transparency: ROM index 0 -> pix_opaque=0, RGB=0.
//    - Assert Reset mid-line: all outputs 0 next cycle; no hit until the next frame_start.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch pipeline.
package sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [4:0] pal_idx_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Ramp palette: red = 8*i, green = 255-8*i, blue = 7*i+3.
    localparam rgb_t PALETTE [32] = '{
        '{8'h00, 8'hFF, 8'h03}, '{8'h08, 8'hF7, 8'h0A}, '{8'h10, 8'hEF, 8'h11}, '{8'h18, 8'hE7, 8'h18},
        '{8'h20, 8'hDF, 8'h1F}, '{8'h28, 8'hD7, 8'h26}, '{8'h30, 8'hCF, 8'h2D}, '{8'h38, 8'hC7, 8'h34},
        '{8'h40, 8'hBF, 8'h3B}, '{8'h48, 8'hB7, 8'h42}, '{8'h50, 8'hAF, 8'h49}, '{8'h58, 8'hA7, 8'h50},
        '{8'h60, 8'h9F, 8'h57}, '{8'h68, 8'h97, 8'h5E}, '{8'h70, 8'h8F, 8'h65}, '{8'h78, 8'h87, 8'h6C},
        '{8'h80, 8'h7F, 8'h73}, '{8'h88, 8'h77, 8'h7A}, '{8'h90, 8'h6F, 8'h81}, '{8'h98, 8'h67, 8'h88},
        '{8'hA0, 8'h5F, 8'h8F}, '{8'hA8, 8'h57, 8'h96}, '{8'hB0, 8'h4F, 8'h9D}, '{8'hB8, 8'h47, 8'hA4},
        '{8'hC0, 8'h3F, 8'hAB}, '{8'hC8, 8'h37, 8'hB2}, '{8'hD0, 8'h2F, 8'hB9}, '{8'hD8, 8'h27, 8'hC0},
        '{8'hE0, 8'h1F, 8'hC7}, '{8'hE8, 8'h17, 8'hCE}, '{8'hF0, 8'h0F, 8'hD5}, '{8'hF8, 8'h07, 8'hDC}
    };

endpackage

// File: rtl/sprite_palette.sv
// Final pipeline stage: registered palette lookup with transparency masking.
module sprite_palette
    import sprite_pkg::*;
#(
    parameter int TRANSP_IDX = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] idx,
    input  logic       hit,
    input  logic       vld_in,
    output rgb_t       rgb,
    output logic       opaque,
    output logic       vld_out
);

    rgb_t rgb_d, rgb_q;
    logic opaque_d, opaque_q;
    logic vld_d, vld_q;

    always_comb begin
        opaque_d = hit & (idx != pal_idx_t'(TRANSP_IDX));
        rgb_d    = opaque_d ? PALETTE[idx] : '0;
        vld_d    = vld_in;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rgb_q    <= '0;
            opaque_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            opaque_q <= opaque_d;
            vld_q    <= vld_d;
        end
    end

    assign rgb     = rgb_q;
    assign opaque  = opaque_q;
    assign vld_out = vld_q;

endmodule

// File: rtl/sprite_renderer.sv
// Sprite fetch stage: hit test, ROM addressing, animation and a 3-cycle aligned pixel output.
// Optional horizontal flip is built in when SPRITE_MIRROR_EN is defined.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 60,
    parameter int SPR_H      = 40,
    parameter int N_FRAMES   = 1,
    parameter int ANIM_DIV   = 8,
    parameter int TRANSP_IDX = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        sprite_vis,
    input  logic        anim_en,
`ifdef SPRITE_MIRROR_EN
    input  logic        mirror,
`endif
    output logic [18:0] rom_addr,
    input  logic [4:0]  rom_data,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        pix_opaque,
    output logic        out_valid
);

    localparam int FRM_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    if (N_FRAMES * SPR_W * SPR_H > (1 << 19)) begin : g_size_check
        $error("sprite_renderer: N_FRAMES*SPR_W*SPR_H exceeds the 19-bit ROM address space");
    end

    logic [9:0]       x_d, x_q, y_d, y_q;
    logic             vis_d, vis_q;
    logic [FRM_W-1:0] frame_d, frame_q;
    logic [DIV_W-1:0] div_d, div_q;
    logic [18:0]      rom_addr_d, rom_addr_q;
    logic             hit1_d, hit1_q, hit2_q;
    logic             vld1_d, vld1_q, vld2_q;
    logic             mirror_on;
    logic [10:0]      px, py, x0, y0, dx, dy, dx_eff;
    rgb_t             rgb;

`ifdef SPRITE_MIRROR_EN
    logic mirror_d, mirror_q;

    always_comb begin
        mirror_d = frame_start ? mirror : mirror_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) mirror_q <= 1'b0;
        else       mirror_q <= mirror_d;
    end

    assign mirror_on = mirror_q;
`else
    assign mirror_on = 1'b0;
`endif

    // Shadow registers and the animation step share the frame_start edge.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        vis_d   = vis_q;
        frame_d = frame_q;
        div_d   = div_q;
        if (frame_start) begin
            x_d   = sprite_x;
            y_d   = sprite_y;
            vis_d = sprite_vis;
            if (anim_en) begin
                if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                    div_d   = '0;
                    frame_d = (frame_q == FRM_W'(N_FRAMES - 1)) ? '0 : frame_q + FRM_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end
    end

    // 11-bit compare so a sprite hanging off the right/bottom edge clips instead of wrapping.
    always_comb begin
        px     = {1'b0, DrawX};
        py     = {1'b0, DrawY};
        x0     = {1'b0, x_q};
        y0     = {1'b0, y_q};
        dx     = px - x0;
        dy     = py - y0;
        dx_eff = mirror_on ? (11'(SPR_W - 1) - dx) : dx;
        hit1_d = vis_q & pix_valid
               & (px >= x0) & (px < x0 + 11'(SPR_W))
               & (py >= y0) & (py < y0 + 11'(SPR_H));
        vld1_d = pix_valid;
        rom_addr_d = rom_addr_q;
        if (hit1_d) begin
            rom_addr_d = 19'(frame_q) * 19'(SPR_W * SPR_H)
                       + 19'(dy) * 19'(SPR_W)
                       + 19'(dx_eff);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q        <= '0;
            y_q        <= '0;
            vis_q      <= 1'b0;
            frame_q    <= '0;
            div_q      <= '0;
            rom_addr_q <= '0;
            hit1_q     <= 1'b0;
            vld1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            vld2_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            vis_q      <= vis_d;
            frame_q    <= frame_d;
            div_q      <= div_d;
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit1_d;
            vld1_q     <= vld1_d;
            hit2_q     <= hit1_q;
            vld2_q     <= vld1_q;
        end
    end

    sprite_palette #(
        .TRANSP_IDX(TRANSP_IDX)
    ) u_palette (
        .Clk     (Clk),
        .Reset   (Reset),
        .idx     (rom_data),
        .hit     (hit2_q),
        .vld_in  (vld2_q),
        .rgb     (rgb),
        .opaque  (pix_opaque),
        .vld_out (out_valid)
    );

    assign rom_addr = rom_addr_q;
    assign red      = rgb.r;
    assign green    = rgb.g;
    assign blue     = rgb.b;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: directed boundary scenarios plus random scans against a behavioural model.
module tb_sprite_renderer;

    localparam int SPR_W    = 60;
    localparam int SPR_H    = 40;
    localparam int N_FRAMES = 2;
    localparam int ANIM_DIV = 2;
    localparam int TRANSP   = 0;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [9:0]  sprite_x = '0;
    logic [9:0]  sprite_y = '0;
    logic        sprite_vis = 1'b0;
    logic        anim_en = 1'b0;
`ifdef SPRITE_MIRROR_EN
    logic        mirror = 1'b0;
`endif
    logic [18:0] rom_addr;
    logic [4:0]  rom_data = '0;
    logic [7:0]  red, green, blue;
    logic        pix_opaque, out_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    sprite_renderer #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(N_FRAMES), .ANIM_DIV(ANIM_DIV), .TRANSP_IDX(TRANSP)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_vis(sprite_vis), .anim_en(anim_en),
`ifdef SPRITE_MIRROR_EN
        .mirror(mirror),
`endif
        .rom_addr(rom_addr), .rom_data(rom_data), .red(red), .green(green), .blue(blue),
        .pix_opaque(pix_opaque), .out_valid(out_valid)
    );

    function automatic logic [4:0] rom_fn(input logic [18:0] a);
        return 5'(a ^ (a >> 5) ^ (a >> 11));
    endfunction

    // External sprite ROM: registered read, one cycle of latency.
    always @(posedge Clk) rom_data <= rom_fn(rom_addr);

    function automatic logic [23:0] pal_model(input int i);
        return {8'(i * 8), 8'(255 - i * 8), 8'(i * 7 + 3)};
    endfunction

    typedef struct {
        bit          vld;
        bit          opq;
        logic [23:0] rgb;
    } exp_t;

    exp_t expq[$];
    int   m_x, m_y, m_vis, m_mir, m_frame, m_div, m_addr;

    function automatic void model_reset();
        exp_t z;
        z.vld = 0; z.opq = 0; z.rgb = '0;
        m_x = 0; m_y = 0; m_vis = 0; m_mir = 0; m_frame = 0; m_div = 0; m_addr = 0;
        expq.delete();
        expq.push_back(z);
        expq.push_back(z);
    endfunction

    // Apply one pixel cycle, predict, advance one clock, compare rom_addr and the output due now.
    task automatic apply_px(input bit fs, input bit pv, input int px, input int py);
        exp_t e, o;
        bit   h;
        int   dx;
        logic [4:0] idx;
        frame_start = fs; pix_valid = pv; DrawX = 10'(px); DrawY = 10'(py);
        h = m_vis != 0 && pv && px >= m_x && px < m_x + SPR_W && py >= m_y && py < m_y + SPR_H;
        if (h) begin
            dx = px - m_x;
            if (m_mir != 0) dx = SPR_W - 1 - dx;
            m_addr = m_frame * SPR_W * SPR_H + (py - m_y) * SPR_W + dx;
        end
        idx   = rom_fn(19'(m_addr));
        e.vld = pv;
        e.opq = h && (int'(idx) != TRANSP);
        e.rgb = e.opq ? pal_model(int'(idx)) : 24'h0;
        expq.push_back(e);
        if (fs) begin
            m_x = int'(sprite_x); m_y = int'(sprite_y); m_vis = int'(sprite_vis);
`ifdef SPRITE_MIRROR_EN
            m_mir = int'(mirror);
`endif
            if (anim_en) begin
                if (m_div == ANIM_DIV - 1) begin
                    m_div = 0;
                    m_frame = (m_frame + 1) % N_FRAMES;
                end else begin
                    m_div = m_div + 1;
                end
            end
        end
        @(negedge Clk);
        frame_start = 1'b0;
        o = expq.pop_front();
        n_vec++;
        if (rom_addr !== 19'(m_addr)) begin
            n_err++;
            $display("FAIL rom_addr px=%0d py=%0d got %0d expected %0d", px, py, rom_addr, m_addr);
        end
        n_vec++;
        if (out_valid !== o.vld) begin
            n_err++;
            $display("FAIL out_valid got %b expected %b", out_valid, o.vld);
        end
        n_vec++;
        if (pix_opaque !== o.opq) begin
            n_err++;
            $display("FAIL pix_opaque got %b expected %b", pix_opaque, o.opq);
        end
        n_vec++;
        if ({red, green, blue} !== o.rgb) begin
            n_err++;
            $display("FAIL rgb got %h expected %h", {red, green, blue}, o.rgb);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_px(0, 0, 0, 0);
    endtask

    task automatic expect_addr(input string nm, input int a);
        n_vec++;
        if (rom_addr !== 19'(a)) begin
            n_err++;
            $display("FAIL %s rom_addr got %0d expected %0d", nm, rom_addr, a);
        end
    endtask

    task automatic latch_sprite(input int x, input int y, input bit vis);
        sprite_x = 10'(x); sprite_y = 10'(y); sprite_vis = vis;
        apply_px(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #3 Reset = 1'b1;
        model_reset();
        repeat (2) @(negedge Clk);
        n_vec++;
        if ({rom_addr, red, green, blue, pix_opaque, out_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %h expected 0",
                     {rom_addr, red, green, blue, pix_opaque, out_valid});
        end
        Reset = 1'b0;
    endtask

    task automatic test_first_pixel();
        latch_sprite(100, 50, 1);
        apply_px(0, 1, 100, 50);
        expect_addr("first_px", 0);
        idle(2);
        n_vec++;
        if (out_valid !== 1'b1 || pix_opaque !== (rom_fn(19'd0) != 5'(TRANSP))) begin
            n_err++;
            $display("FAIL first_px_out got valid=%b opaque=%b expected valid=1 opaque=%b",
                     out_valid, pix_opaque, rom_fn(19'd0) != 5'(TRANSP));
        end
    endtask

    task automatic test_boundaries();
        apply_px(0, 1, 159, 89);
        expect_addr("corner_br", 2399);
        apply_px(0, 1, 160, 89);
        expect_addr("right_miss", 2399);
        idle(2);
        n_vec++;
        if (pix_opaque !== 1'b0 || {red, green, blue} !== 24'h0) begin
            n_err++;
            $display("FAIL right_miss_out got opaque=%b rgb=%h expected 0", pix_opaque, {red, green, blue});
        end
        apply_px(0, 1, 99, 50);
        expect_addr("left_miss", 2399);
        apply_px(0, 1, 100, 89);
        expect_addr("corner_bl", 2340);
        apply_px(0, 1, 159, 50);
        expect_addr("corner_tr", 59);
        apply_px(0, 1, 120, 90);
        expect_addr("bottom_miss", 59);
        idle(3);
    endtask

    task automatic test_clipping();
        latch_sprite(620, 50, 1);
        apply_px(0, 1, 639, 50);
        expect_addr("clip_edge", 19);
        for (int i = 0; i < 20; i++) begin
            apply_px(0, 1, i, 50);
            expect_addr("clip_nowrap", 19);
        end
        idle(3);
    endtask

    task automatic test_shadow();
        latch_sprite(100, 50, 1);
        sprite_x = 10'd300;
        apply_px(0, 1, 159, 50);
        expect_addr("shadow_old_a", 59);
        apply_px(0, 1, 100, 50);
        expect_addr("shadow_old_b", 0);
        apply_px(0, 1, 301, 50);
        expect_addr("shadow_new_early", 0);
        apply_px(1, 1, 101, 50);
        expect_addr("shadow_fs_same_cycle", 1);
        apply_px(0, 1, 100, 50);
        expect_addr("shadow_old_miss", 1);
        apply_px(0, 1, 300, 51);
        expect_addr("shadow_new_hit", 60);
        idle(3);
    endtask

    task automatic test_anim();
        int exp_base[4] = '{0, 2400, 2400, 0};
        latch_sprite(100, 50, 1);
        model_reset_frame();
        anim_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_px(1, 0, 0, 0);
            apply_px(0, 1, 101, 50);
            expect_addr("anim_step", exp_base[i] + 1);
        end
        anim_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_px(1, 0, 0, 0);
            apply_px(0, 1, 102, 50);
            expect_addr("anim_frozen", 2);
        end
        idle(3);
    endtask

    // The animation walk assumes it starts at frame 0 with a cleared divider.
    task automatic model_reset_frame();
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        latch_sprite(100, 50, 1);
    endtask

`ifdef SPRITE_MIRROR_EN
    task automatic test_mirror();
        mirror = 1'b1;
        latch_sprite(100, 50, 1);
        apply_px(0, 1, 100, 50);
        expect_addr("mirror_left", 59);
        apply_px(0, 1, 159, 51);
        expect_addr("mirror_right", 60);
        mirror = 1'b0;
        latch_sprite(100, 50, 1);
        idle(3);
    endtask
`endif

    task automatic test_transparency();
        latch_sprite(100, 50, 1);
        apply_px(0, 1, 100, 50);
        idle(2);
        n_vec++;
        if (out_valid !== 1'b1 || pix_opaque !== 1'b0 || {red, green, blue} !== 24'h0) begin
            n_err++;
            $display("FAIL transparent got valid=%b opaque=%b rgb=%h expected 1,0,0",
                     out_valid, pix_opaque, {red, green, blue});
        end
        apply_px(0, 1, 101, 50);
        idle(2);
        n_vec++;
        if (pix_opaque !== 1'b1 || {red, green, blue} !== pal_model(int'(rom_fn(19'd1)))) begin
            n_err++;
            $display("FAIL opaque_px got opaque=%b rgb=%h expected 1 rgb=%h",
                     pix_opaque, {red, green, blue}, pal_model(int'(rom_fn(19'd1))));
        end
    endtask

    task automatic test_midline_reset();
        latch_sprite(100, 50, 1);
        apply_px(0, 1, 110, 60);
        apply_px(0, 1, 111, 60);
        Reset = 1'b1;
        #1;
        n_vec++;
        if ({rom_addr, red, green, blue, pix_opaque, out_valid} !== '0) begin
            n_err++;
            $display("FAIL midline_reset got %h expected 0",
                     {rom_addr, red, green, blue, pix_opaque, out_valid});
        end
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 110; i < 116; i++) begin
            apply_px(0, 1, i, 60);
            expect_addr("post_reset_nohit", 0);
        end
        apply_px(1, 0, 0, 0);
        apply_px(0, 1, 110, 60);
        expect_addr("post_reset_fs_hit", 610);
        idle(3);
    endtask

    task automatic test_random();
        int px, py;
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) begin
                sprite_x   = 10'($urandom_range(0, 639));
                sprite_y   = 10'($urandom_range(0, 479));
                sprite_vis = ($urandom_range(0, 3) != 0);
                anim_en    = $urandom_range(0, 1);
`ifdef SPRITE_MIRROR_EN
                mirror     = $urandom_range(0, 1);
`endif
                apply_px(1, $urandom_range(0, 1), $urandom_range(0, 639), $urandom_range(0, 479));
            end else begin
                if ($urandom_range(0, 3) != 0) begin
                    px = int'(sprite_x) - 4 + int'($urandom_range(0, 67));
                    py = int'(sprite_y) - 2 + int'($urandom_range(0, 43));
                end else begin
                    px = $urandom_range(0, 639);
                    py = $urandom_range(0, 479);
                end
                if (px < 0) px = 0;
                if (px > 639) px = 639;
                if (py < 0) py = 0;
                if (py > 479) py = 479;
                apply_px(0, ($urandom_range(0, 7) != 0), px, py);
            end
        end
        anim_en = 1'b0;
        idle(3);
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_first_pixel();
        test_boundaries();
        test_clipping();
        test_shadow();
        test_anim();
`ifdef SPRITE_MIRROR_EN
        test_mirror();
`endif
        test_transparency();
        test_midline_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
